uart_tx_serializer: RTL and testbench

//  Parametrised UART transmitter: accepts a parallel word over a valid/ready handshake and

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_bit_timer.sv | 40 ++++
 rtl/uart_tx_serializer.sv | 122 ++++++++++++
 tb/tb_uart_tx_serializer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module : uart_pkg
//  Shared UART definitions: frame states, parity modes and line levels.
//  Rev    : 1.0  initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module : uart_bit_timer
//  Divides clk by CLKS_PER_BIT; bit_done_o flags the last cycle of each bit.
//  Rev    : 1.0  initial release
// ============================================================================
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic bit_done_o
);

  localparam int              CW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   C_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign bit_done_o = (cnt_q == C_LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || bit_done_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module : uart_tx_serializer
//  UART transmitter: valid/ready word in, LSB-first framed serial line out.
//  Rev    : 1.0  initial release
// ============================================================================
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam int           IW          = $clog2(DATA_BITS);
  localparam logic [IW-1:0] C_LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] C_LAST_STOP = IW'(STOP_BITS - 1);
  localparam logic          C_PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 1 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      (PARITY_EN != 0 && PARITY_EN != 1) ||
      (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
    $error("uart_tx_serializer: illegal parameter combination");
  end

  uart_state_t          state_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [IW-1:0]        bit_idx_q;
  logic                 par_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 w_bit_done;
  logic                 w_accept;

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (state_q == IDLE),
    .bit_done_o (w_bit_done)
  );

  // The final stop cycle also accepts, so back-to-back frames have no idle gap.
  assign tx_ready = (state_q == IDLE) ||
                    (state_q == STOP && bit_idx_q == C_LAST_STOP && w_bit_done);
  assign w_accept = tx_valid && tx_ready;
  assign tx       = tx_q;
  assign busy     = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      par_q     <= 1'b0;
      tx_q      <= LINE_IDLE;
      busy_q    <= 1'b0;
    end else if (w_accept) begin
      state_q   <= START;
      shreg_q   <= tx_data;
      par_q     <= (^tx_data) ^ C_PAR_MODE;
      bit_idx_q <= '0;
      tx_q      <= LINE_START;
      busy_q    <= 1'b1;
    end else if (w_bit_done) begin
      case (state_q)
        START: begin
          state_q   <= DATA;
          bit_idx_q <= '0;
          tx_q      <= shreg_q[0];
        end
        DATA: begin
          if (bit_idx_q == C_LAST_DATA) begin
            bit_idx_q <= '0;
            if (PARITY_EN != 0) begin
              state_q <= PARITY;
              tx_q    <= par_q;
            end else begin
              state_q <= STOP;
              tx_q    <= LINE_STOP;
            end
          end else begin
            bit_idx_q <= bit_idx_q + 1'b1;
            shreg_q   <= shreg_q >> 1;
            tx_q      <= shreg_q[1];
          end
        end
        PARITY: begin
          state_q   <= STOP;
          bit_idx_q <= '0;
          tx_q      <= LINE_STOP;
        end
        STOP: begin
          if (bit_idx_q == C_LAST_STOP) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            bit_idx_q <= bit_idx_q + 1'b1;
          end
          tx_q <= LINE_IDLE;
        end
        default: begin
          tx_q <= LINE_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module : tb_uart_tx_serializer
//  Directed checks of uart_tx_serializer in three parameter configurations.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] v   = 3'b000;
  logic [7:0] d   = 8'h00;
  wire  [2:0] rdy;
  wire  [2:0] txl;
  wire  [2:0] bsy;
  int         sel = 0;
  int         n_vec = 0;
  int         n_miss = 0;

  always #5 clk = ~clk;

  // dut0: defaults; dut1: even parity, 2 stop bits, 4 clk/bit; dut2: odd parity, 1 clk/bit
  uart_tx_serializer u_dut0 (
    .clk(clk), .rst(rst), .tx_valid(v[0]), .tx_data(d),
    .tx_ready(rdy[0]), .tx(txl[0]), .busy(bsy[0])
  );
  uart_tx_serializer #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .tx_valid(v[1]), .tx_data(d),
    .tx_ready(rdy[1]), .tx(txl[1]), .busy(bsy[1])
  );
  uart_tx_serializer #(.CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .clk(clk), .rst(rst), .tx_valid(v[2]), .tx_data(d),
    .tx_ready(rdy[2]), .tx(txl[2]), .busy(bsy[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one word, samples each bit mid-way; flags = {busy after, busy last, ready last, ready before last}
  task automatic frame(input int s, input int c, input int f, input logic [7:0] data,
                       input int glitch_k, output logic [31:0] bits, output logic [3:0] flags);
    sel  = s;
    v[s] = 1'b1;
    d    = data;
    tick();
    v[s]  = 1'b0;
    d     = 8'h00;
    bits  = '0;
    flags = '0;
    for (int k = 0; k < f; k++) begin
      if (k == glitch_k) begin
        v[s] = 1'b1;
        d    = 8'hFF;
      end else begin
        v[s] = 1'b0;
      end
      if (k % c == c / 2) bits[k / c] = txl[s];
      if (k == f - 2) flags[0] = rdy[s];
      if (k == f - 1) begin
        flags[1] = rdy[s];
        flags[2] = bsy[s];
      end
      tick();
    end
    v[s]     = 1'b0;
    flags[3] = bsy[s];
  endtask

  initial begin
    logic [31:0] bits;
    logic [3:0]  flags;
    logic        r_b;
    logic        t_b;
    logic        b_b;
    int          bad;

    // Reset and idle line
    repeat (3) tick();
    chk("rst_tx", {29'd0, txl}, 32'h7);
    chk("rst_ready", {29'd0, rdy}, 32'h7);
    chk("rst_busy", {29'd0, bsy}, 32'h0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (txl !== 3'b111 || rdy !== 3'b111 || bsy !== 3'b000) bad++;
    end
    chk("idle_100", bad, 0);

    // Default frame, 8'hA5
    frame(0, 16, 160, 8'hA5, -1, bits, flags);
    chk("a5_bits", bits, 32'h34A);
    chk("a5_ready_busy", {28'd0, flags}, 32'h6);
    chk("a5_idle_after", {30'd0, rdy[0], txl[0]}, 32'h3);

    // Even parity, two stop bits: 12 bits x 4 clk
    frame(1, 4, 48, 8'h07, -1, bits, flags);
    chk("par_even_bits", bits, 32'hE0E);
    chk("par_even_ready_busy", {28'd0, flags}, 32'h6);

    // Odd parity, one clk per bit
    frame(2, 1, 11, 8'h07, -1, bits, flags);
    chk("par_odd_bits", bits, 32'h40E);
    chk("par_odd_ready_busy", {28'd0, flags}, 32'h6);

    // Back-to-back with data changed right after the first accept
    sel  = 0;
    v[0] = 1'b1;
    d    = 8'h55;
    tick();
    d    = 8'h0F;
    bits = '0;
    r_b  = 1'b0;
    t_b  = 1'b1;
    b_b  = 1'b0;
    for (int k = 0; k < 320; k++) begin
      if (k % 16 == 8) bits[k / 16] = txl[0];
      if (k == 159) r_b = rdy[0];
      if (k == 160) begin
        t_b  = txl[0];
        b_b  = bsy[0];
        v[0] = 1'b0;
        d    = 8'h00;
      end
      tick();
    end
    chk("b2b_bits", bits, {12'd0, 10'h21E, 10'h2AA});
    chk("b2b_ready_last_stop", {31'd0, r_b}, 32'h1);
    chk("b2b_no_gap", {30'd0, b_b, t_b}, 32'h2);

    // Valid pulse while busy is ignored and not queued
    frame(0, 16, 160, 8'h12, 40, bits, flags);
    chk("busy_valid_bits", bits, 32'h224);
    chk("busy_valid_ready_busy", {28'd0, flags}, 32'h6);
    bad = 0;
    for (int i = 0; i < 320; i++) begin
      if (txl[0] !== 1'b1 || bsy[0] !== 1'b0) bad++;
      tick();
    end
    chk("busy_valid_no_extra", bad, 0);

    // Reset during data bit 3 of 8'h00
    v[0] = 1'b1;
    d    = 8'h00;
    tick();
    v[0] = 1'b0;
    repeat (4 * 16 + 5) tick();
    chk("mid_pre_rst", {30'd0, bsy[0], txl[0]}, 32'h2);
    rst = 1'b1;
    #1;
    chk("mid_rst_async", {30'd0, bsy[0], txl[0]}, 32'h1);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_idle", {29'd0, rdy[0], bsy[0], txl[0]}, 32'h5);
    frame(0, 16, 160, 8'h3C, -1, bits, flags);
    chk("post_rst_bits", bits, 32'h278);
    chk("post_rst_ready_busy", {28'd0, flags}, 32'h6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
